// File: rtl/wb_pkg.sv
// Shared Wishbone interconnect definitions: arbiter state encoding and bus-width helpers.
// Pure declarations; no logic, no latency, no flow control.
package wb_pkg;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_BUSY = 1'b1;

    typedef enum logic {
        ST_IDLE = ARB_IDLE,
        ST_BUSY = ARB_BUSY
    } arb_state_e;

    function automatic int WB_SEL_WIDTH(input int data_width);
        return data_width / 8;
    endfunction

    // Index width for an N-entry select; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set request scanning from ptr_i upwards, wrapping.
// Purely combinational, zero latency; vld_o low when nothing requests.
module rr_select
    import wb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    localparam logic [IW:0] N_L = (IW+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  pos;
    logic [IW:0]    sum;

    // Rotating the doubled vector puts ptr_i at bit 0, so the lowest set bit wins.
    always_comb begin
        dbl   = {req_i, req_i};
        rot   = N'(dbl >> ptr_i);
        vld_o = |rot;
        pos   = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = IW'(k);
            end
        end
        sum   = {1'b0, ptr_i} + {1'b0, pos};
        idx_o = (sum >= N_L) ? IW'(sum - N_L) : sum[IW-1:0];
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin share of one Wishbone slave among MASTER_COUNT masters; grant held while owner cyc is high.
// One-cycle arbitration and handover; forward/return paths combinational from the registered owner.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int ADDR_WIDTH   = 32,
    parameter  int TAG_WIDTH    = 4,
    parameter  int MASTER_COUNT = 2,
    parameter  int TIMEOUT      = 255,
    localparam int SEL_WIDTH    = WB_SEL_WIDTH(DATA_WIDTH),
    localparam int IW           = idx_width(MASTER_COUNT)
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic [MASTER_COUNT-1:0]            master_cyc,
    input  logic [MASTER_COUNT-1:0]            master_stb,
    input  logic [MASTER_COUNT-1:0]            master_we,
    input  logic [MASTER_COUNT*TAG_WIDTH-1:0]  master_tag,
    input  logic [MASTER_COUNT*SEL_WIDTH-1:0]  master_sel,
    input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] master_adr,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0] master_mosi,
    output logic [MASTER_COUNT*DATA_WIDTH-1:0] master_miso,
    output logic [MASTER_COUNT-1:0]            master_ack,
    output logic [MASTER_COUNT-1:0]            master_err,
    output logic                               slave_cyc,
    output logic                               slave_stb,
    output logic                               slave_we,
    output logic [TAG_WIDTH-1:0]               slave_tag,
    output logic [SEL_WIDTH-1:0]               slave_sel,
    output logic [ADDR_WIDTH-1:0]              slave_adr,
    output logic [DATA_WIDTH-1:0]              slave_mosi,
    input  logic [DATA_WIDTH-1:0]              slave_miso,
    input  logic                               slave_ack,
    input  logic                               slave_err,
    output logic [MASTER_COUNT-1:0]            grant
);

    arb_state_e              state_q;
    logic [IW-1:0]           g_q, p_q, g_inc, sel_ptr, sel_idx;
    logic                    sel_vld, busy, own_cyc, own_stb, to_err;
    logic [MASTER_COUNT-1:0] g_oh;

    assign busy    = (state_q == ST_BUSY);
    assign g_inc   = (g_q == IW'(MASTER_COUNT-1)) ? '0 : g_q + IW'(1);
    assign g_oh    = MASTER_COUNT'(1) << g_q;
    // While busy the only scan that matters is the handover one, starting after the owner.
    assign sel_ptr = busy ? g_inc : p_q;

    rr_select #(.N(MASTER_COUNT)) u_rr_select (
        .req_i (master_cyc),
        .ptr_i (sel_ptr),
        .idx_o (sel_idx),
        .vld_o (sel_vld)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            p_q     <= '0;
        end else if (!busy) begin
            if (sel_vld) begin
                g_q     <= sel_idx;
                state_q <= ST_BUSY;
            end
        end else if (!own_cyc) begin
            p_q <= g_inc;
            if (sel_vld) begin
                g_q <= sel_idx;
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

    always_comb begin
        own_cyc    = master_cyc[0];
        own_stb    = master_stb[0];
        slave_we   = master_we[0];
        slave_tag  = master_tag[TAG_WIDTH-1:0];
        slave_sel  = master_sel[SEL_WIDTH-1:0];
        slave_adr  = master_adr[ADDR_WIDTH-1:0];
        slave_mosi = master_mosi[DATA_WIDTH-1:0];
        for (int i = 1; i < MASTER_COUNT; i++) begin
            if (g_q == IW'(i)) begin
                own_cyc    = master_cyc[i];
                own_stb    = master_stb[i];
                slave_we   = master_we[i];
                slave_tag  = master_tag[i*TAG_WIDTH +: TAG_WIDTH];
                slave_sel  = master_sel[i*SEL_WIDTH +: SEL_WIDTH];
                slave_adr  = master_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
                slave_mosi = master_mosi[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign slave_cyc   = busy & own_cyc;
    assign slave_stb   = slave_cyc & own_stb;
    assign grant       = busy ? g_oh : '0;
    assign master_ack  = busy ? (g_oh & {MASTER_COUNT{slave_ack}}) : '0;
    assign master_err  = busy ? (g_oh & {MASTER_COUNT{slave_err | to_err}}) : '0;
    assign master_miso = {MASTER_COUNT{slave_miso}};

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int            CW      = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
            logic [CW-1:0] cnt_q;
            logic          to_err_q;

            // The error pulse itself counts as a termination, so the next window restarts after it.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    cnt_q    <= '0;
                    to_err_q <= 1'b0;
                end else if (!slave_stb || slave_ack || slave_err || to_err_q) begin
                    cnt_q    <= '0;
                    to_err_q <= 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_q    <= '0;
                    to_err_q <= 1'b1;
                end else begin
                    cnt_q    <= cnt_q + CW'(1);
                    to_err_q <= 1'b0;
                end
            end
            assign to_err = to_err_q;
        end else begin : g_no_wd
            assign to_err = 1'b0;
        end
    endgenerate

endmodule
